// File: rtl/sram_host_port.sv
// Host-side SRAM port: LOAD streams words into the SRAM from a base address, DRAIN reads
// a region back out through a 2-entry skid FIFO so reads keep flowing under backpressure.
module sram_host_port #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 17
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              done,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] fifo_q [2];
  logic [DATA_W-1:0] fifo_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;

  logic              load_beat;
  logic              pop;
  logic              push;
  logic              rd_req;
  logic [2:0]        occ;
  logic [ADDR_W-1:0] addr;

  assign cmd_ready = (state_q == IDLE);
  assign s_ready   = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign m_valid   = (fifo_cnt_q != 2'd0);
  assign m_data    = fifo_q[rd_ptr_q];

  // The first DRAIN read issues in the accept cycle so the first word is visible two cycles later.
  // A pop in the same cycle frees a slot in time for the data of a read issued now.
  always_comb begin
    load_beat = (state_q == LOAD) && s_valid;
    pop       = m_valid && m_ready;
    push      = inflight_q;
    occ       = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
    rd_req    = ((state_q == IDLE) && cmd_valid && cmd_op && (cmd_len != '0)) ||
                ((state_q == DRAIN) && (cnt_q < len_q) && (occ < (3'd2 + {2'b00, pop})));
    addr      = (state_q == IDLE) ? cmd_base : base_q + cnt_q[ADDR_W-1:0];
    mem_cs    = load_beat || rd_req;
    mem_oe    = rd_req;
    mem_web   = !load_beat;
    mem_addr  = mem_cs ? addr : '0;
    mem_wdata = load_beat ? s_data : '0;
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    inflight_d = rd_req;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);
    if (push) fifo_d[wr_ptr_q] = mem_rdata;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          base_d  = cmd_base;
          len_d   = cmd_len;
          cnt_d   = rd_req ? LEN_W'(1) : '0;
          if (cmd_len == '0) state_d = DONE;
          else if (cmd_op)   state_d = DRAIN;
          else               state_d = LOAD;
        end
      end
      LOAD: begin
        if (load_beat) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = DONE;
        end
      end
      DRAIN: begin
        if (rd_req) cnt_d = cnt_q + LEN_W'(1);
        if (pop && (fifo_cnt_q == 2'd1) && !inflight_q && (cnt_q == len_q)) state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

endmodule
